// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, width constants and the
// key-schedule state encoding.
package aes_pkg;

    localparam int KEY_W   = 256;
    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Held as a constant table so synthesis never depends on a memory file path.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    function automatic logic [7:0] rcon_of(input logic [2:0] n);
        return (n < 3'd7) ? RCON[n] : 8'h00;
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    always_comb begin
        word_out = '0;
        for (int b = 0; b < 4; b++) begin
            word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
        end
    end

endmodule

// File: rtl/key_expand_256.sv
// Iterative AES-256 key schedule: emits round keys 0..14 over a valid/ready
// handshake while keeping only an 8-word sliding window (hi = older, lo = newer).
module key_expand_256
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [3:0]         rk_idx,
    output logic [BLOCK_W-1:0] round_key,
    output logic               done
);

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [BLOCK_W-1:0]   hi_q, hi_d;
    logic [BLOCK_W-1:0]   lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 even_round;
    logic [WORD_W-1:0]    last_word;
    logic [WORD_W-1:0]    sub_in;
    logic [WORD_W-1:0]    sub_out;
    logic [WORD_W-1:0]    t_word;
    logic [WORD_W-1:0]    n0, n1, n2, n3;

    assign accept = (state_q == EMIT) && rk_ready;

    // (idx+1) even <=> idx odd; that round uses RotWord plus Rcon[(idx+1)/2].
    assign even_round = idx_q[0];
    assign last_word  = lo_q[WORD_W-1:0];

    always_comb begin
        sub_in = even_round ? {last_word[23:0], last_word[31:24]} : last_word;
        t_word = sub_out ^ (even_round ? {rcon_of(idx_q[3:1]), 24'h0} : {WORD_W{1'b0}});
        n0     = hi_q[127:96] ^ t_word;
        n1     = hi_q[95:64]  ^ n0;
        n2     = hi_q[63:32]  ^ n1;
        n3     = hi_q[31:0]   ^ n2;
    end

    sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    idx_d   = 4'd0;
                    hi_d    = key_in[255:128];
                    lo_d    = key_in[127:0];
                end
            end
            EMIT: begin
                if (accept) begin
                    if (idx_q == 4'd14) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else if (idx_q == 4'd0) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        hi_d  = lo_q;
                        lo_d  = {n0, n1, n2, n3};
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Round 0 is the upper key half; from round 1 on, lo always holds the newest key.
    assign busy      = (state_q == EMIT);
    assign rk_valid  = (state_q == EMIT);
    assign rk_idx    = idx_q;
    assign round_key = (state_q != EMIT) ? {BLOCK_W{1'b0}} : ((idx_q == 4'd0) ? hi_q : lo_q);
    assign done      = done_q;

endmodule

// File: tb/tb_key_expand_256.sv
// Self-checking bench for key_expand_256 against a from-first-principles
// AES-256 key expansion (S-box derived from GF(2^8) inverse + affine map).
module tb_key_expand_256;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   ref_sbox [256];
    logic [7:0]   ref_rcon [8];
    logic [127:0] ref_rk   [15];
    logic [127:0] obs_rk   [15];

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expand_256 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .done      (done)
    );

    always #5 clk = ~clk;

    // GF(2^8) arithmetic used to build the reference S-box and Rcon values.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] ref_subword(input logic [31:0] w);
        return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
        return v;
    endfunction

    task automatic buildTables();
        logic [7:0] inv;
        logic [7:0] rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        ref_rcon[0] = 8'h00;
        for (int j = 1; j < 8; j++) begin
            ref_rcon[j] = rc;
            rc = xtime(rc);
        end
    endtask

    // Textbook 60-word expansion, grouped into 15 round keys.
    task automatic computeReference(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int j = 0; j < 8; j++) w[j] = key[255 - 32*j -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)
                t = ref_subword({t[23:0], t[31:24]}) ^ {ref_rcon[i/8], 24'h0};
            else if (i % 8 == 4)
                t = ref_subword(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},  128'(busy),     128'(0));
        checkOutput({tag, "_valid"}, 128'(rk_valid), 128'(0));
        checkOutput({tag, "_done"},  128'(done),     128'(0));
        checkOutput({tag, "_idx"},   128'(rk_idx),   128'(0));
        checkOutput({tag, "_key"},   round_key,      128'(0));
    endtask

    // Runs one schedule from the current negedge. Returns at the negedge of
    // the done cycle (or after the reset sequence when rst_at >= 0).
    task automatic applyStimulus(input logic [255:0] key, input int stall_pct,
                                 input bit spam, input int rst_at);
        int r;
        computeReference(key);
        start    = 1'b1;
        key_in   = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand256();
        r = 0;
        for (int cyc = 0; cyc < 400 && r < 15; cyc++) begin
            checkOutput($sformatf("r%0d_valid", r), 128'(rk_valid), 128'(1));
            checkOutput($sformatf("r%0d_busy", r),  128'(busy),     128'(1));
            checkOutput($sformatf("r%0d_done", r),  128'(done),     128'(0));
            checkOutput($sformatf("r%0d_idx", r),   128'(rk_idx),   128'(r));
            checkOutput($sformatf("r%0d_key", r),   round_key,      ref_rk[r]);
            if (r == rst_at) begin
                rk_ready = 1'b1;
                #2 rst = 1'b1;
                #1 checkAllZero("async_rst");
                @(negedge clk);
                checkAllZero("rst_held");
                rst = 1'b0;
                rk_ready = 1'b0;
                @(negedge clk);
                checkAllZero("post_rst");
                return;
            end
            obs_rk[r] = round_key;
            rk_ready = ($urandom_range(99) >= stall_pct);
            if (spam) begin
                start  = 1'($urandom_range(1));
                key_in = rand256();
            end
            @(negedge clk);
            if (rk_ready) r++;
        end
        if (r < 15) begin
            checks++;
            failures++;
            $error("[TB] FAIL beat_budget observed=%0d expected=15", r);
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        checkOutput("done_pulse", 128'(done),     128'(1));
        checkOutput("done_busy",  128'(busy),     128'(0));
        checkOutput("done_valid", 128'(rk_valid), 128'(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        buildTables();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.3 vector, no backpressure: beats must be back to back.
        applyStimulus(KEY_C3, 0, 1'b0, -1);
        checkOutput("c3_rk0",  obs_rk[0],  128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("c3_rk1",  obs_rk[1],  128'h101112131415161718191a1b1c1d1e1f);
        checkOutput("c3_rk2",  obs_rk[2],  128'ha573c29fa176c498a97fce93a572c09c);
        checkOutput("c3_rk14", obs_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        @(negedge clk);
        checkOutput("c3_done_clear", 128'(done), 128'(0));

        // FIPS-197 A.3 vector under random backpressure.
        applyStimulus(KEY_A3, 30, 1'b0, -1);
        checkOutput("a3_last_word", 128'(obs_rk[14][31:0]), 128'(32'h706c631e));
        @(negedge clk);

        // Start pulses with other keys while busy must be ignored.
        applyStimulus(rand256(), 30, 1'b1, -1);
        @(negedge clk);

        // Reset mid-expansion, then a clean schedule, then a start in the done cycle.
        applyStimulus(KEY_C3, 0, 1'b0, 7);
        applyStimulus(rand256(), 0, 1'b0, -1);
        applyStimulus(rand256(), 0, 1'b0, -1);
        @(negedge clk);
        checkOutput("chain_done_clear", 128'(done), 128'(0));

        for (int k = 0; k < 3; k++) begin
            applyStimulus(rand256(), 30, 1'b0, -1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
